// File: rtl/bht_gshare_pht.sv
// gshare branch predictor. A table of saturating counters is indexed by PC XOR a speculative
// global history. It self-initialises after reset and forwards a same-cycle update to the predict port.
module bht_gshare_pht #(
  parameter int ENTRIES = 256,
  parameter int CTR_W   = 2,
  parameter int GHR_W   = 8,
  parameter int PC_LSB  = 2,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ready_o,
  input  logic             pred_valid_i,
  input  logic [31:0]      pred_pc_i,
  output logic             pred_taken_o,
  output logic [IDX_W-1:0] pred_idx_o,
  output logic [GHR_W-1:0] pred_ghr_o,
  input  logic             upd_valid_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i,
  input  logic             upd_mispredict_i,
  input  logic [GHR_W-1:0] upd_ghr_i,
  output logic [GHR_W-1:0] ghr_o
);

  localparam logic [CTR_W-1:0] WEAK_T    = CTR_W'(1 << (CTR_W - 1));
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ENTRIES - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;

  logic [CTR_W-1:0] pht_q [ENTRIES];
  logic             pht_we;
  logic [IDX_W-1:0] pht_waddr;
  logic [CTR_W-1:0] pht_wdata;

  logic             run;
  logic [IDX_W-1:0] ghr_ext;
  logic [IDX_W-1:0] idx;
  logic [CTR_W-1:0] upd_ctr;
  logic [CTR_W-1:0] upd_ctr_new;
  logic [CTR_W-1:0] pred_ctr;
  logic [GHR_W-1:0] ghr_restore;
  logic [GHR_W-1:0] ghr_shift;
  logic             misc_unused;

  function automatic logic [CTR_W-1:0] sat_next(input logic [CTR_W-1:0] c, input logic taken);
    logic [CTR_W-1:0] r;
    if (taken) r = (&c) ? c : c + CTR_W'(1);
    else       r = (|c) ? c - CTR_W'(1) : c;
    return r;
  endfunction

  assign run = (state_q == ST_RUN);

  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_W-1:0] = ghr_q;
  end

  assign idx         = pred_pc_i[PC_LSB +: IDX_W] ^ ghr_ext;
  assign upd_ctr     = pht_q[upd_idx_i];
  assign upd_ctr_new = sat_next(upd_ctr, upd_taken_i);
  // Forward an update to the same entry so back-to-back branches see fresh state.
  assign pred_ctr    = (upd_valid_i && (upd_idx_i == idx)) ? upd_ctr_new : pht_q[idx];

  assign ready_o      = run;
  assign pred_taken_o = run & pred_ctr[CTR_W-1];
  assign pred_idx_o   = run ? idx : '0;
  assign pred_ghr_o   = run ? ghr_q : '0;
  assign ghr_o        = ghr_q;

  generate
    if (GHR_W == 1) begin : g_ghr_one
      assign ghr_restore = upd_taken_i;
      assign ghr_shift   = pred_taken_o;
    end else begin : g_ghr_wide
      assign ghr_restore = {upd_ghr_i[GHR_W-2:0], upd_taken_i};
      assign ghr_shift   = {ghr_q[GHR_W-2:0], pred_taken_o};
    end
  endgenerate

  // Only a slice of the PC feeds the index; the top history bit is shifted out on restore.
  assign misc_unused = ^{pred_pc_i, upd_ghr_i};

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    ghr_d      = ghr_q;
    pht_we     = 1'b0;
    pht_waddr  = '0;
    pht_wdata  = '0;
    case (state_q)
      ST_INIT: begin
        pht_we     = 1'b1;
        pht_waddr  = init_ptr_q;
        pht_wdata  = WEAK_T;
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == LAST_IDX) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (upd_valid_i) begin
          pht_we    = 1'b1;
          pht_waddr = upd_idx_i;
          pht_wdata = upd_ctr_new;
        end
        // A mispredict rewinds history and discards this cycle's speculative shift.
        if (upd_valid_i && upd_mispredict_i) ghr_d = ghr_restore;
        else if (pred_valid_i)               ghr_d = ghr_shift;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      ghr_q      <= ghr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pht_we) pht_q[pht_waddr] <= pht_wdata;
  end

endmodule

// File: tb/tb_bht_gshare_pht.sv
// Directed bench for bht_gshare_pht (default parameters): init sweep, saturation, bypass,
// history shift/restore and asynchronous reset during both sweep and run.
module tb_bht_gshare_pht;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready_o;
  logic        pred_valid_i;
  logic [31:0] pred_pc_i;
  logic        pred_taken_o;
  logic [7:0]  pred_idx_o;
  logic [7:0]  pred_ghr_o;
  logic        upd_valid_i;
  logic [7:0]  upd_idx_i;
  logic        upd_taken_i;
  logic        upd_mispredict_i;
  logic [7:0]  upd_ghr_i;
  logic [7:0]  ghr_o;

  int total  = 0;
  int passes = 0;

  bht_gshare_pht dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ready_o          (ready_o),
    .pred_valid_i     (pred_valid_i),
    .pred_pc_i        (pred_pc_i),
    .pred_taken_o     (pred_taken_o),
    .pred_idx_o       (pred_idx_o),
    .pred_ghr_o       (pred_ghr_o),
    .upd_valid_i      (upd_valid_i),
    .upd_idx_i        (upd_idx_i),
    .upd_taken_i      (upd_taken_i),
    .upd_mispredict_i (upd_mispredict_i),
    .upd_ghr_i        (upd_ghr_i),
    .ghr_o            (ghr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_upd(input logic [7:0] idx, input logic taken, input logic misp, input logic [7:0] g);
    upd_valid_i      = 1'b1;
    upd_idx_i        = idx;
    upd_taken_i      = taken;
    upd_mispredict_i = misp;
    upd_ghr_i        = g;
    tick();
    upd_valid_i      = 1'b0;
    upd_mispredict_i = 1'b0;
  endtask

  task automatic pred_at(input logic [7:0] idx, input string tag, input logic exp);
    pred_pc_i = {22'd0, idx, 2'b00};
    #1;
    check(tag, pred_taken_o, exp);
  endtask

  // Release reset just after an edge and confirm ready rises exactly after edge 256.
  task automatic release_and_wait(input string tag);
    int errs = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (ready_o !== (k >= 256)) errs++;
    end
    check(tag, errs, 0);
  endtask

  task automatic sweep_all(input string tag);
    int errs = 0;
    for (int i = 0; i < 256; i++) begin
      pred_pc_i = i * 4;
      #1;
      if (pred_taken_o !== 1'b1 || pred_idx_o !== 8'(i)) errs++;
    end
    check(tag, errs, 0);
  endtask

  initial begin
    rst_n            = 1'b1;
    pred_valid_i     = 1'b0;
    pred_pc_i        = 32'h0000_0abc;
    upd_valid_i      = 1'b0;
    upd_idx_i        = '0;
    upd_taken_i      = 1'b0;
    upd_mispredict_i = 1'b0;
    upd_ghr_i        = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", ready_o, 0);
    check("rst_ghr", ghr_o, 0);
    check("rst_taken", pred_taken_o, 0);
    check("rst_idx", pred_idx_o, 0);
    check("rst_pghr", pred_ghr_o, 0);

    // Predict requests during the sweep must be ignored.
    pred_valid_i = 1'b1;
    release_and_wait("init_ready_256");
    pred_valid_i = 1'b0;
    check("init_ghr_held", ghr_o, 0);
    sweep_all("init_all_weak_taken");

    // Saturation at idx 5: 10 -> 11 -> 11 -> 11, then down to 00 and held.
    do_upd(8'd5, 1'b1, 1'b0, 8'h00); pred_at(8'd5, "sat_t1", 1'b1);
    do_upd(8'd5, 1'b1, 1'b0, 8'h00); pred_at(8'd5, "sat_t2", 1'b1);
    do_upd(8'd5, 1'b1, 1'b0, 8'h00); pred_at(8'd5, "sat_t3", 1'b1);
    do_upd(8'd5, 1'b0, 1'b0, 8'h00); pred_at(8'd5, "sat_n1", 1'b1);
    do_upd(8'd5, 1'b0, 1'b0, 8'h00); pred_at(8'd5, "sat_n2", 1'b0);
    do_upd(8'd5, 1'b0, 1'b0, 8'h00); pred_at(8'd5, "sat_n3", 1'b0);
    do_upd(8'd5, 1'b0, 1'b0, 8'h00); pred_at(8'd5, "sat_n4", 1'b0);
    do_upd(8'd5, 1'b0, 1'b0, 8'h00); pred_at(8'd5, "sat_n5_floor", 1'b0);
    do_upd(8'd5, 1'b1, 1'b0, 8'h00); pred_at(8'd5, "sat_floor_then_t", 1'b0);
    check("sat_ghr_untouched", ghr_o, 0);

    // Bypass: idx 9 at 01, same-cycle taken update makes it 10.
    do_upd(8'd9, 1'b0, 1'b0, 8'h00); pred_at(8'd9, "byp_pre", 1'b0);
    upd_valid_i = 1'b1; upd_idx_i = 8'd9; upd_taken_i = 1'b1;
    pred_at(8'd9, "byp_same_cycle", 1'b1);
    upd_idx_i = 8'd10;
    pred_at(8'd9, "byp_other_idx", 1'b0);
    upd_idx_i = 8'd9;
    tick();
    upd_valid_i = 1'b0;
    pred_at(8'd9, "byp_written", 1'b1);

    // History shift: three taken predictions from ghr=0 at untouched entries 0x80..0x83.
    pred_valid_i = 1'b1;
    pred_pc_i = 32'h0000_0200;
    #1;
    check("ghr_p1_pghr", pred_ghr_o, 8'h00);
    check("ghr_p1_taken", pred_taken_o, 1);
    tick();
    check("ghr_p2_pghr", pred_ghr_o, 8'h01);
    tick();
    check("ghr_p3_pghr", pred_ghr_o, 8'h03);
    check("ghr_p3_idx", pred_idx_o, 8'h83);
    tick();
    pred_valid_i = 1'b0;
    check("ghr_after3", ghr_o, 8'h07);

    // Restore: {0x78[6:0],0}=0xF0, then {0x12[6:0],0}=0x24 overriding the predict shift.
    do_upd(8'd200, 1'b0, 1'b1, 8'h78);
    check("rst_ghr_f0", ghr_o, 8'hF0);
    pred_valid_i = 1'b1;
    do_upd(8'd201, 1'b0, 1'b1, 8'h12);
    pred_valid_i = 1'b0;
    check("restore_24", ghr_o, 8'h24);
    do_upd(8'd202, 1'b1, 1'b0, 8'hFF);
    check("upd_no_misp_hold", ghr_o, 8'h24);
    upd_mispredict_i = 1'b1;
    tick();
    upd_mispredict_i = 1'b0;
    check("misp_no_valid_hold", ghr_o, 8'h24);

    // Asynchronous reset mid-run, then again mid-sweep at init_ptr=100.
    #2 rst_n = 1'b0;
    #1;
    check("run_rst_ready", ready_o, 0);
    check("run_rst_ghr", ghr_o, 0);
    check("run_rst_taken", pred_taken_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 100; k++) tick();
    check("mid_sweep_ready", ready_o, 0);
    #2 rst_n = 1'b0;
    #1;
    check("sweep_rst_ready", ready_o, 0);
    release_and_wait("reinit_ready_256");
    check("reinit_ghr", ghr_o, 0);
    pred_at(8'd5, "reinit_idx5", 1'b1);
    sweep_all("reinit_all_weak_taken");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
